lfsr_checker: RTL

- Receive-side counterpart of the team's 8-bit LFSR pattern generator.
- Consumes the serial pseudo-random bit stream, self-synchronises to it, declares lock, then counts bit errors and detects loss of lock.
- Error count low byte is optionally shown on two 7-segment displays, same board usage as the generator's display.
- Polynomial matches the generator: next bit = s[4]^s[3]^s[2]^s[0], register shifts right, new bit enters bit 7.

---
 rtl/lfsr_pkg.sv | 41 ++++
 rtl/lfsr_checker_hex7seg.sv | 35 +++
 rtl/lfsr_checker.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator and checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps at bits 4,3,2,0; the register shifts right and the new bit enters bit 7.
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0001_1101;

    typedef enum logic [1:0] {
        SEED,
        HUNT,
        LOCKED
    } state_e;

    // Active-low seven-segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Next bit the LFSR produces from its current contents.
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & TAP_MASK);
    endfunction

endpackage

// File: rtl/lfsr_checker_hex7seg.sv
// Hex nibble to active-low seven-segment pattern (gfedcba).
// Latency: combinational.
// Backpressure: none.
module hex7seg
    import lfsr_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg_o = SEG_0;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_0;
        endcase
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit LFSR stream: seeds, hunts for lock, counts bit errors.
// Latency: outputs registered on the edge consuming the bit; HEX digits one cycle after err_cnt (LFSR_CHK_HEX_EN).
// Backpressure: none; rx_valid=0 freezes all state, gaps of any length are tolerated.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int LOSS_LIMIT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_LIMIT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_LIMIT - 1);
    localparam logic [2:0]    FILL_LAST  = 3'(LFSR_W - 1);

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   s_q, s_d;
    logic [2:0]          fill_q, fill_d;
    logic [MW-1:0]       match_q, match_d;
    logic [LW-1:0]       miss_q, miss_d;
    logic                err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic                exp_bit;

    // Next-state logic: seed the register, hunt for a clean run, then flywheel while locked.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        exp_bit     = lfsr_fb(s_q);

        if (rx_valid) begin
            case (state_q)
                SEED: begin
                    s_d = {rx_bit, s_q[LFSR_W-1:1]};
                    if (fill_q == FILL_LAST) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = HUNT;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                HUNT: begin
                    s_d = {rx_bit, s_q[LFSR_W-1:1]};
                    // An all-zero register predicts zeros forever, so it must never count as a match.
                    if ((rx_bit == exp_bit) && (s_q != '0)) begin
                        if (match_q == MATCH_LAST) begin
                            match_d = '0;
                            miss_d  = '0;
                            state_d = LOCKED;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Load the prediction, not the received bit, so one bad bit cannot corrupt later predictions.
                    s_d = {exp_bit, s_q[LFSR_W-1:1]};
                    if (rx_bit != exp_bit) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (miss_q == MISS_LAST) begin
                            miss_d  = '0;
                            fill_d  = '0;
                            state_d = SEED;
                        end else begin
                            miss_d = miss_q + LW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = SEED;
                    fill_d  = '0;
                end
            endcase
        end

        // Clear takes priority over an error counted in the same cycle.
        if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef LFSR_CHK_HEX_EN
    logic [7:0] err_lo;
    logic [6:0] seg0, seg1;
    logic [6:0] hex0_q, hex1_q;

    assign err_lo = 8'(err_cnt_q);

    hex7seg u_hex0 (
        .nib_i (err_lo[3:0]),
        .seg_o (seg0)
    );

    hex7seg u_hex1 (
        .nib_i (err_lo[7:4]),
        .seg_o (seg1)
    );

    // Display registers trail err_cnt by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hex0_q <= SEG_0;
            hex1_q <= SEG_0;
        end else begin
            hex0_q <= seg0;
            hex1_q <= seg1;
        end
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
`else
    assign HEX0 = SEG_BLANK;
    assign HEX1 = SEG_BLANK;
`endif

endmodule
